// File: rtl/keypad_scanner_4x4_if.sv
// Key-code hand-off between the keypad scanner and its consumer.
// Valid/ack handshake plus debounced status flags.
interface keypad_scanner_4x4_if;
  logic [3:0] KeyCode;
  logic       KeyValid;
  logic       KeyAck;
  logic       Pressed;
  logic       Overrun;

  modport master (
    output KeyCode,
    output KeyValid,
    output Pressed,
    output Overrun,
    input  KeyAck
  );

  modport slave (
    input  KeyCode,
    input  KeyValid,
    input  Pressed,
    input  Overrun,
    output KeyAck
  );
endinterface

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: row walk, debounce, one code per press.
// Codes are handed off on a valid/ack interface with sticky overrun.
module keypad_scanner_4x4 #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [3:0]                  Col,
  output logic [3:0]                  Row,
  keypad_scanner_4x4_if.master        key
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_TICKS);

  localparam logic [1:0] ST_SCAN = 2'd0;
  localparam logic [1:0] ST_DEB  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

  logic [3:0]    col_s1;
  logic [3:0]    col_s2;
  logic [PW-1:0] presc;
  logic          tick;

  logic [1:0] state;
  logic [1:0] state_n;
  logic [1:0] row_idx;
  logic [1:0] row_n;
  logic [1:0] cap_col;
  logic [1:0] cap_n;
  logic [3:0] count;
  logic [3:0] count_n;
  logic [3:0] count_inc;

  logic       any_low;
  logic       cap_low;
  logic [1:0] low_col;
  logic       accept;

  logic [3:0] code_q;
  logic       valid_q;
  logic       overrun_q;

  assign tick      = (presc == PRE_LAST);
  assign any_low   = ~&col_s2;
  assign cap_low   = ~col_s2[cap_col];
  assign count_inc = count + 4'd1;

  // Lowest column index wins when several columns are low.
  always_comb begin
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s2[i]) low_col = 2'(i);
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row_idx;
    count_n = count;
    cap_n   = cap_col;
    accept  = 1'b0;
    if (tick) begin
      unique case (state)
        ST_SCAN: begin
          if (any_low) begin
            cap_n   = low_col;
            count_n = 4'd1;
            if (DEBOUNCE_TICKS == 1) begin
              accept  = 1'b1;
              state_n = ST_HELD;
              count_n = 4'd0;
            end else begin
              state_n = ST_DEB;
            end
          end else begin
            row_n = row_idx + 2'd1;
          end
        end
        ST_DEB: begin
          if (cap_low) begin
            count_n = count_inc;
            if (count_inc == DB_LAST) begin
              accept  = 1'b1;
              state_n = ST_HELD;
              count_n = 4'd0;
            end
          end else begin
            state_n = ST_SCAN;
            count_n = 4'd0;
            row_n   = row_idx + 2'd1;
          end
        end
        ST_HELD: begin
          // Release needs an unbroken run of high samples.
          count_n = cap_low ? 4'd0 : count_inc;
          if (!cap_low && count_inc == DB_LAST) begin
            state_n = ST_SCAN;
            count_n = 4'd0;
            row_n   = row_idx + 2'd1;
          end
        end
        default: begin
          state_n = ST_SCAN;
          count_n = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      col_s1    <= 4'hF;
      col_s2    <= 4'hF;
      presc     <= '0;
      state     <= ST_SCAN;
      row_idx   <= 2'd0;
      cap_col   <= 2'd0;
      count     <= 4'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      col_s1  <= Col;
      col_s2  <= col_s1;
      presc   <= tick ? '0 : presc + PW'(1);
      state   <= state_n;
      row_idx <= row_n;
      cap_col <= cap_n;
      count   <= count_n;
      // An ack in the accept cycle frees the slot for the new code.
      if (accept) begin
        if (!valid_q || key.KeyAck) begin
          code_q  <= {row_idx, cap_n};
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && key.KeyAck) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign Row          = ~(4'b0001 << row_idx);
  assign key.KeyCode  = code_q;
  assign key.KeyValid = valid_q;
  assign key.Pressed  = (state == ST_HELD);
  assign key.Overrun  = overrun_q;

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Bench for keypad_scanner_4x4: directed sequences, code table and
// a randomized run against a tick-level keypad reference model.
module tb_keypad_scanner_4x4;

  localparam int SD = 4;
  localparam int DT = 3;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [3:0]  Col;
  logic [3:0]  Row;
  logic [15:0] mask = '0;
  int          cyc = -1;
  int          n_chk = 0;
  int          n_fail = 0;

  int         mrow, mst, mcnt, capr, capc;
  logic       mvalid, movr;
  logic [3:0] mcode;

  typedef struct {
    int         row;
    logic [3:0] pat;
    logic [3:0] code;
  } vec_t;

  vec_t tbl [8];

  keypad_scanner_4x4_if kif ();

  keypad_scanner_4x4 #(
    .SCAN_DIV(SD),
    .DEBOUNCE_TICKS(DT)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Col(Col),
    .Row(Row),
    .key(kif.master)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= Rst ? -1 : cyc + 1;

  // Physical keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    Col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (Row[r] === 1'b0) begin
        for (int c = 0; c < 4; c++) begin
          if (mask[r*4+c]) Col[c] = 1'b0;
        end
      end
    end
  end

  function automatic logic [3:0] rowpat(int i);
    logic [3:0] p;
    p = 4'hF;
    p[i%4] = 1'b0;
    return p;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic at(int k);
    while (cyc < k) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    kif.KeyAck = 1'b0;
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  task automatic wait_sig(string nm, int which, logic val, int bound);
    int n;
    n = 0;
    while (((which == 0) ? kif.KeyValid : kif.Pressed) !== val
           && n < bound) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check(nm, (which == 0) ? kif.KeyValid : kif.Pressed, val);
  endtask

  task automatic m_accept();
    if (!mvalid) begin
      mvalid = 1'b1;
      mcode  = {2'(capr), 2'(capc)};
    end else begin
      movr = 1'b1;
    end
  endtask

  // One scan tick of the reference keypad reader.
  task automatic model_tick();
    logic [3:0] cv;
    cv = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (mask[mrow*4+c]) cv[c] = 1'b0;
    end
    if (mst == 0) begin
      if (cv != 4'hF) begin
        capr = mrow;
        for (int c = 3; c >= 0; c--) if (!cv[c]) capc = c;
        mcnt = 1;
        if (mcnt == DT) begin
          m_accept();
          mst  = 2;
          mcnt = 0;
        end else begin
          mst = 1;
        end
      end else begin
        mrow = (mrow + 1) % 4;
      end
    end else if (mst == 1) begin
      if (!cv[capc]) begin
        mcnt++;
        if (mcnt == DT) begin
          m_accept();
          mst  = 2;
          mcnt = 0;
        end
      end else begin
        mst  = 0;
        mcnt = 0;
        mrow = (mrow + 1) % 4;
      end
    end else begin
      mcnt = cv[capc] ? mcnt + 1 : 0;
      if (mcnt == DT) begin
        mst  = 0;
        mcnt = 0;
        mrow = (mrow + 1) % 4;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 4'b0101, 4'h5};
    tbl[1] = '{2, 4'b1101, 4'h9};
    tbl[2] = '{0, 4'b0111, 4'h3};
    tbl[3] = '{3, 4'b1011, 4'hE};
    tbl[4] = '{1, 4'b1110, 4'h4};
    tbl[5] = '{3, 4'b0000, 4'hC};
    tbl[6] = '{0, 4'b1000, 4'h0};
    tbl[7] = '{2, 4'b0011, 4'hA};
    kif.KeyAck = 1'b0;

    // reset state and idle row walk
    mask = '0;
    do_reset();
    check("rst_row", Row, 4'b1110);
    check("rst_valid", kif.KeyValid, 1'b0);
    check("rst_pressed", kif.Pressed, 1'b0);
    check("rst_overrun", kif.Overrun, 1'b0);
    for (int k = 0; k < 40; k++) begin
      at(k);
      check("idle_walk", Row, rowpat((k + 1) / 4));
    end

    // press r2c1, then ack and release
    mask = 16'h0001 << 9;
    do_reset();
    at(18);
    check("press_pre", kif.KeyValid, 1'b0);
    at(19);
    check("press_valid", kif.KeyValid, 1'b1);
    check("press_code", kif.KeyCode, 4'h9);
    check("press_pressed", kif.Pressed, 1'b1);
    for (int k = 20; k <= 30; k++) begin
      at(k);
      check("press_hold", {Row, kif.KeyValid}, {4'b1011, 1'b1});
    end
    kif.KeyAck = 1'b1;
    at(31);
    kif.KeyAck = 1'b0;
    check("ack_clear", kif.KeyValid, 1'b0);
    mask = '0;
    at(42);
    check("rel_pre", kif.Pressed, 1'b1);
    at(43);
    check("rel_pressed", kif.Pressed, 1'b0);
    check("rel_row", Row, 4'b0111);
    at(47);
    check("rel_walk", Row, 4'b1110);

    // bounce on r0c3, then a stable press
    mask = 16'h0008;
    do_reset();
    for (int t = 0; t < 12; t++) begin
      at(4 * t + 3);
      check("bounce_valid", {kif.KeyValid, kif.Pressed}, 2'b00);
      if (t == 1) check("bounce_row", Row, 4'b1101);
      mask[3] = ~mask[3];
    end
    mask = 16'h0008;
    wait_sig("stable_valid", 0, 1'b1, 80);
    check("stable_code", kif.KeyCode, 4'h3);

    // overrun: second accept with the first code still pending
    mask = 16'h0010;
    do_reset();
    at(14);
    check("ovr_pre", kif.KeyValid, 1'b0);
    at(15);
    check("ovr_first", {kif.KeyValid, kif.KeyCode}, {1'b1, 4'h4});
    at(16);
    mask = 16'h0001 << 14;
    at(42);
    check("ovr_before", {kif.Overrun, kif.Pressed}, 2'b00);
    at(43);
    check("ovr_set", kif.Overrun, 1'b1);
    check("ovr_code", {kif.KeyValid, kif.KeyCode}, {1'b1, 4'h4});
    check("ovr_pressed", kif.Pressed, 1'b1);

    // same, but ack lands on the accepting edge
    mask = 16'h0010;
    do_reset();
    at(16);
    check("ack2_first", kif.KeyCode, 4'h4);
    mask = 16'h0001 << 14;
    at(42);
    kif.KeyAck = 1'b1;
    at(43);
    kif.KeyAck = 1'b0;
    check("ack2_code", {kif.KeyValid, kif.KeyCode}, {1'b1, 4'hE});
    check("ack2_overrun", kif.Overrun, 1'b0);

    // reset while debouncing r1c0
    mask = 16'h0010;
    do_reset();
    at(9);
    check("rstdb_row", Row, 4'b1101);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    check("rstdb_row0", Row, 4'b1110);
    check("rstdb_valid", {kif.KeyValid, kif.Pressed}, 2'b00);
    Rst = 1'b0;
    mask = '0;
    at(30);
    check("rstdb_none", kif.KeyValid, 1'b0);

    // code table incl. multi-column priority
    for (int i = 0; i < 8; i++) begin
      mask = '0;
      for (int c = 0; c < 4; c++) begin
        if (!tbl[i].pat[c]) mask[tbl[i].row*4+c] = 1'b1;
      end
      do_reset();
      wait_sig("tbl_valid", 0, 1'b1, 80);
      check("tbl_code", kif.KeyCode, tbl[i].code);
      check("tbl_pressed", kif.Pressed, 1'b1);
      kif.KeyAck = 1'b1;
      @(posedge Clk);
      #1;
      kif.KeyAck = 1'b0;
      check("tbl_ack", kif.KeyValid, 1'b0);
      mask = '0;
      wait_sig("tbl_release", 1, 1'b0, 80);
    end

    // randomized keypad activity against the reference model
    mask = '0;
    do_reset();
    mrow = 0; mst = 0; mcnt = 0; capr = 0; capc = 0;
    mvalid = 1'b0; movr = 1'b0; mcode = 4'h0;
    for (int s = 0; s < 250; s++) begin
      logic ack;
      int   r;
      ack = ($urandom_range(0, 1) == 0);
      at(4 * s);
      kif.KeyAck = ack;
      at(4 * s + 1);
      kif.KeyAck = 1'b0;
      if (ack) mvalid = 1'b0;
      check("rnd_ack", kif.KeyValid, mvalid);
      at(4 * s + 3);
      model_tick();
      check("rnd_tick",
            {Row, kif.KeyValid, kif.KeyCode, kif.Pressed, kif.Overrun},
            {rowpat(mrow), mvalid, mcode, (mst == 2), movr});
      r = $urandom_range(0, 19);
      if (r == 15) mask = '0;
      else if (r >= 16 && r <= 18) mask = 16'h0001 << $urandom_range(0, 15);
      else if (r == 19)
        mask = (16'h0001 << $urandom_range(0, 15))
             | (16'h0001 << $urandom_range(0, 15));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
